// File: rtl/matmul_pkg.sv
// Shared constants and types for the matmul sequencing controller and its token pipe.
package matmul_pkg;

    localparam int ROWS       = 64;
    localparam int ADDR_W     = 6;
    localparam int OUT_ADDR_W = 2 * ADDR_W;
    localparam int RD_LAT     = 1;
    localparam int DP_LAT     = 4;
    localparam int PIPE_DEPTH = RD_LAT + DP_LAT;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [OUT_ADDR_W-1:0] addr_out;
    } token_t;

endpackage

// File: rtl/matmul_token_pipe.sv
// Free-running valid+address shift register that follows each issued pair through
// the BRAM read and dot-product latency.
module matmul_token_pipe
    import matmul_pkg::*;
#(
    parameter int DEPTH = PIPE_DEPTH,
    parameter int TAP   = RD_LAT
) (
    input  logic   clk,
    input  logic   rst_n,
    input  token_t push,
    output logic   tap_valid,
    output token_t tail,
    output logic   empty
);

    token_t stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < DEPTH; n++) begin
                stage[n] <= '0;
            end
        end else begin
            stage[0] <= push;
            for (int n = 1; n < DEPTH; n++) begin
                stage[n] <= stage[n-1];
            end
        end
    end

    assign tap_valid = stage[TAP-1].valid;
    assign tail      = stage[DEPTH-1];

    // Looks one edge ahead: only the output stage may still hold a token, so the
    // pipe is empty once this cycle's write has been taken.
    always_comb begin
        empty = 1'b1;
        for (int n = 0; n < DEPTH - 1; n++) begin
            if (stage[n].valid) begin
                empty = 1'b0;
            end
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the 64x128 by 64x128^T matmul core: walks all (i,j) pairs and writes out[i*64+j].
// Optional MATMUL_SEQ_PERF_CNT_EN adds cycle_cnt and stall_cnt performance counters.
//
//   state | meaning
//   IDLE  | host owns buffers, waiting for start
//   ISSUE | issuing one (i,j) pair per cycle with dp_ready
//   DRAIN | all pairs issued, waiting for the token pipe to empty
//   DONE  | done flag up, waiting for start to drop
module matmul_seq_ctrl
    import matmul_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  host_sel,
    output logic                  en_A,
    output logic                  en_B,
    output logic [ADDR_W-1:0]     addr_A,
    output logic [ADDR_W-1:0]     addr_B,
    input  logic                  dp_ready,
    output logic                  dp_in_valid,
    output logic                  en_out,
    output logic                  we_out,
    output logic [OUT_ADDR_W-1:0] addr_out
`ifdef MATMUL_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           cycle_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    state_t                state, state_nxt;
    logic [OUT_ADDR_W-1:0] idx, idx_nxt;
    logic                  issue;
    logic                  pipe_empty;
    token_t                push, tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // idx is {i,j}; the +1 carries j into i on the row wrap.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        issue     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        host_sel  = 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    idx_nxt   = '0;
                end
            end
            ISSUE: begin
                host_sel = 1'b0;
                busy     = 1'b1;
                if (dp_ready) begin
                    issue   = 1'b1;
                    idx_nxt = idx + OUT_ADDR_W'(1);
                    if (idx == '1) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                host_sel = 1'b0;
                busy     = 1'b1;
                if (pipe_empty) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!start) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign en_A   = issue;
    assign en_B   = issue;
    assign addr_A = idx[OUT_ADDR_W-1:ADDR_W];
    assign addr_B = idx[ADDR_W-1:0];

    always_comb begin
        push       = '0;
        push.valid = issue;
        if (issue) begin
            push.addr_out = idx;
        end
    end

    matmul_token_pipe #(
        .DEPTH (PIPE_DEPTH),
        .TAP   (RD_LAT)
    ) u_token_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .tap_valid (dp_in_valid),
        .tail      (tail),
        .empty     (pipe_empty)
    );

    assign en_out   = tail.valid;
    assign we_out   = tail.valid;
    assign addr_out = tail.addr_out;

`ifdef MATMUL_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (busy && cycle_cnt != '1) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (state == ISSUE && !dp_ready && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencing controller for the 64x128 by 64x128 (B transposed) matmul core.
- Owns the A/B input buffers and the output buffer while computing; host AXI ports own them otherwise.
- Walks all (i,j) row pairs, issues BRAM reads, tracks the 128-wide dot-product pipeline, writes each result to out[i*64+j], then reports done.
- Sits between the host-facing top level and the dot-product datapath plus buffers.

Parameters:
- ROWS, 64, rows of A and rows of B (output is ROWS x ROWS).
- ADDR_W, 6, A/B buffer address width (log2 ROWS).
- OUT_ADDR_W, 12, output buffer address width (2*ADDR_W).
- RD_LAT, 1, A/B BRAM read latency in cycles.
- DP_LAT, 4, dot-product datapath latency in cycles, from operand valid to result valid.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level request; sampled only in IDLE.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  completion flag.
- host_sel  out  1  1 = host AXI owns all buffer ports; 0 = controller owns them.
- en_A, en_B  out  1  read enables to the A/B buffers.
- addr_A, addr_B  out  ADDR_W  row addresses i and j.
- dp_ready  in  1  datapath can accept a new operand pair this cycle.
- dp_in_valid  out  1  operands are present on the BRAM outputs (RD_LAT after issue).
- en_out, we_out  out  1  output buffer write strobe (both high together).
- addr_out  out  OUT_ADDR_W  output write address i*ROWS+j.

Behaviour:
- Reset values: busy=0, done=0, host_sel=1, all enables 0, all addresses 0, pipeline tokens cleared, state IDLE.
- Reset mid-operation aborts immediately; no write strobe after reset asserts.
- States:
  - IDLE: host_sel=1. Moves to ISSUE when start=1, with i=j=0.
  - ISSUE: host_sel=0. Each cycle with dp_ready=1 issues the pair (i,j): en_A=en_B=1, addr_A=i, addr_B=j, and pushes a token carrying addr_out=i*ROWS+j into a (RD_LAT+DP_LAT)-deep shift register.
    - After an issue, j increments. On j=ROWS-1, j wraps to 0 and i increments.
    - Issuing (ROWS-1,ROWS-1) moves the FSM to DRAIN.
    - dp_ready=0 means no issue: enables low, counters held, bubble token inserted.
  - DRAIN: no issues. Tokens keep shifting. When the shift register is empty, go to DONE.
  - DONE: done=1, busy=0, host_sel=1. Returns to IDLE when start=0; done clears in that same transition.
    - If start stays high, done stays high and no restart occurs.
- Token pipeline: it is free-running and not stalled by dp_ready. dp_in_valid is the token valid at depth RD_LAT. en_out=we_out=1 with addr_out equal to the token at depth RD_LAT+DP_LAT.
- Latency: with dp_ready held at 1 and start sampled at edge 0:
  - issues occur at cycles 1..ROWS*ROWS;
  - the write for issue k occurs RD_LAT+DP_LAT cycles after it;
  - done rises one cycle after the last write (defaults: last write at cycle 4101, done at 4102).
- start toggling during ISSUE or DRAIN is ignored.
- Writes are in strict row-major order; no address is written twice per run.
- addr_out arithmetic is unsigned, exactly OUT_ADDR_W bits; {i,j} concatenation is legal since ROWS is a power of two.

Optional Feature:
- MATMUL_SEQ_PERF_CNT_EN defined: adds output cycle_cnt (32 bits).
  - Clears on the IDLE-to-ISSUE transition.
  - Increments every cycle busy=1, saturating at all-ones.
  - Holds its value in DONE and IDLE.
  - Also adds stall_cnt (32 bits), counting ISSUE cycles with dp_ready=0.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Shared package matmul_pkg:
  - state enum (IDLE, ISSUE, DRAIN, DONE);
  - constants ROWS, ADDR_W, OUT_ADDR_W, RD_LAT, DP_LAT;
  - token struct {valid, addr_out}.
- One natural sub-module, matmul_token_pipe: a parameterised-depth valid+address shift register exposing taps at RD_LAT and at full depth, plus an empty flag.

Test Plan:
- Basic run, dp_ready=1: assert start, hold high.
  - Expect 4096 issues at consecutive cycles and addr_out sequence 0..4095 in order.
  - Expect each write 5 cycles after its issue, done=1 at cycle 4102, then done held while start=1.
- Row wrap: observe the issue of (0,63) then (1,0).
  - Expect addr_A 0 to 1 and addr_B 63 to 0, with writes to out addresses 63 then 64.
- Backpressure: dp_ready=0 for 3 cycles at issue k=100 and at the last issue.
  - Expect counters held and no duplicate or missing addr_out.
  - Expect done delayed by exactly 6 cycles (4108).
- Restart: in DONE drop start for 1 cycle, then raise it.
  - Expect done to fall in IDLE, a second full run, and done again.
- Reset mid-run: pull rst_n low at issue k=2000.
  - Expect immediate host_sel=1, busy=0, no further writes.
  - After release and start, expect the sequence to restart at addr_out=0.
- Perf counters (macro defined): dp_ready low for 3 cycles.
  - Expect cycle_cnt=4104 and stall_cnt=3 held in DONE.
